// File: rtl/gnt_sched_pkg.sv
// gnt_sched_pkg: shared state encoding, default latency window and delay clamp helper for gnt_scheduler
package gnt_sched_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} gnt_state_e;
  localparam int GS_MIN_DLY = 3;
  localparam int GS_MAX_DLY = 5;
  typedef struct packed {
    logic [31:0] d;
    logic        oor;
  } clamp_t;
  function automatic clamp_t clamp_dly(input logic [31:0] sel, input logic [31:0] lo, input logic [31:0] hi);
    clamp_t c;
    c.d   = sel < lo ? lo : sel > hi ? hi : sel;
    c.oor = (sel < lo) || (sel > hi);
    return c;
  endfunction
endpackage

// File: rtl/gnt_scheduler_edge_det.sv
// edge_det: one-flop rise/fall detector with asynchronous active-low reset
module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic q;
  // previous-cycle copy of the input; resets low so a level held through reset reads as a rise
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= 1'b0;
    else q <= d;
  assign rise = d & ~q;
  assign fall = ~d & q;
endmodule

// File: rtl/gnt_scheduler.sv
// gnt_scheduler: req-rise to single-cycle gnt with clamped latency; GNT_SCHEDULER_SVA_EN adds handshake assertions
module gnt_scheduler
  import gnt_sched_pkg::*;
#(
  parameter int MIN_DLY = GS_MIN_DLY,
  parameter int MAX_DLY = GS_MAX_DLY,
  parameter int DLY_W   = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [DLY_W-1:0] dly_sel,
  output logic             gnt,
  output logic             busy,
  output logic             clamp_err,
  output logic             abort,
  output logic [CNT_W-1:0] grant_cnt
);
  gnt_state_e       state, state_n;
  logic [DLY_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] grant_cnt_n;
  logic             gnt_n, busy_n, abort_n, clamp_err_n;
  logic             rise, fall;
  clamp_t           c;
  edge_det u_req_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (req),
    .rise (rise),
    .fall (fall)
  );
  // in WAIT/HOLD req was high on the previous edge, so a fall there is exactly req going low
  always_comb begin
    c           = clamp_dly(32'(dly_sel), MIN_DLY, MAX_DLY);
    state_n     = state;
    cnt_n       = cnt;
    gnt_n       = 1'b0;
    busy_n      = busy;
    abort_n     = 1'b0;
    clamp_err_n = clamp_err;
    grant_cnt_n = grant_cnt;
    case (state)
      IDLE: if (rise) begin
        state_n     = WAIT;
        cnt_n       = DLY_W'(c.d - 32'd1);
        busy_n      = 1'b1;
        clamp_err_n = clamp_err | c.oor;
      end
      WAIT: if (fall) begin
        state_n = IDLE;
        busy_n  = 1'b0;
        abort_n = 1'b1;
      end else if (cnt == DLY_W'(1)) begin
        state_n     = HOLD;
        busy_n      = 1'b0;
        gnt_n       = 1'b1;
        grant_cnt_n = grant_cnt + CNT_W'(1);
      end else begin
        cnt_n = cnt - DLY_W'(1);
      end
      HOLD: state_n = fall ? IDLE : HOLD;
      default: state_n = IDLE;
    endcase
  end
  // all outputs are registered so gnt/abort are clean single-cycle pulses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      gnt       <= 1'b0;
      busy      <= 1'b0;
      abort     <= 1'b0;
      clamp_err <= 1'b0;
      grant_cnt <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      gnt       <= gnt_n;
      busy      <= busy_n;
      abort     <= abort_n;
      clamp_err <= clamp_err_n;
      grant_cnt <= grant_cnt_n;
    end
`ifdef GNT_SCHEDULER_SVA_EN
  a_lat: assert property (@(posedge clk) disable iff (!rst_n)
    $rose(req) ##1 req[*(MIN_DLY-1)] |-> ##[1:MAX_DLY-MIN_DLY+1] ($rose(gnt) or !req))
    $info("a_lat pass at %0t", $time); else $error("a_lat fail at %0t", $time);
  a_pulse: assert property (@(posedge clk) disable iff (!rst_n) gnt |=> !gnt)
    $info("a_pulse pass at %0t", $time); else $error("a_pulse fail at %0t", $time);
  a_busy: assert property (@(posedge clk) disable iff (!rst_n) $rose(gnt) |-> $past(busy))
    $info("a_busy pass at %0t", $time); else $error("a_busy fail at %0t", $time);
`else
`endif
endmodule
